// File: rtl/branch_condition_resolver.sv
// Conditional-branch resolver: holds a decoded branch until every in-flight
// flag-setting instruction has committed, then evaluates the condition code
// against the committed NZCV flags and presents taken/next-PC on a
// valid/ready result channel.
module branch_condition_resolver #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PENDING_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        flags,
  input  logic              flag_issue,
  input  logic              flag_commit,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic [7:0]        stall_cycles,
  output logic              err
);

  localparam int unsigned PendW = $clog2(PENDING_MAX + 1);

  typedef enum logic [1:0] {StIdle, StWait, StEval, StDone} state_e;

  state_e            state_q, state_d;
  logic [PendW-1:0]  pending_q, pending_d;
  logic              err_q, err_d;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [7:0]        stall_q, stall_d;

  // Condition code table over flags {N, Z, C, V}.
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    unique case (cc)
      4'd0:    cond_true = z;
      4'd1:    cond_true = ~z;
      4'd2:    cond_true = c;
      4'd3:    cond_true = ~c;
      4'd4:    cond_true = n;
      4'd5:    cond_true = ~n;
      4'd6:    cond_true = v;
      4'd7:    cond_true = ~v;
      4'd8:    cond_true = c & ~z;
      4'd9:    cond_true = ~c | z;
      4'd10:   cond_true = (n == v);
      4'd11:   cond_true = (n != v);
      4'd12:   cond_true = ~z & (n == v);
      4'd13:   cond_true = z | (n != v);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  // Pending flag-writer count; over/underflow holds the count and sets sticky err.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    unique case ({flag_issue, flag_commit})
      2'b10: begin
        if (pending_q == PendW'(PENDING_MAX)) err_d = 1'b1;
        else pending_d = pending_q + 1'b1;
      end
      2'b01: begin
        if (pending_q == '0) err_d = 1'b1;
        else pending_d = pending_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Branch FSM; wait decisions look at pending_d so a same-cycle issue counts as older.
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    off_d    = off_q;
    taken_d  = taken_q;
    target_d = target_q;
    stall_d  = stall_q;
    unique case (state_q)
      StIdle: begin
        if (br_valid) begin
          cond_d  = br_cond;
          pc_d    = br_pc;
          off_d   = br_offset;
          stall_d = '0;
          if (br_cond[3:1] == 3'b111) begin
            // AL/NV do not depend on flags: resolve straight away.
            taken_d  = ~br_cond[0];
            target_d = br_cond[0] ? br_pc + ADDR_W'(1) : br_pc + br_offset;
            state_d  = StDone;
          end else if (pending_d == '0) begin
            state_d = StEval;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
        if (pending_d == '0) state_d = StEval;
      end
      StEval: begin
        taken_d  = cond_true(cond_q, flags);
        target_d = taken_d ? pc_q + off_q : pc_q + ADDR_W'(1);
        state_d  = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      err_q     <= 1'b0;
      cond_q    <= '0;
      pc_q      <= '0;
      off_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      cond_q    <= cond_d;
      pc_q      <= pc_d;
      off_q     <= off_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      stall_q   <= stall_d;
    end
  end

  assign br_ready     = (state_q == StIdle);
  assign res_valid    = (state_q == StDone);
  assign res_taken    = taken_q;
  assign res_target   = target_q;
  assign stall_cycles = stall_q;
  assign err          = err_q;

endmodule

// File: tb/tb_branch_condition_resolver.sv
// Bench for branch_condition_resolver: directed scenarios plus a sweep of all
// condition codes; expected results are queued at issue and checked on handshake.
module tb_branch_condition_resolver;

  logic        clk;
  logic        rst;
  logic [3:0]  flags;
  logic        flag_issue;
  logic        flag_commit;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [15:0] res_target;
  logic [7:0]  stall_cycles;
  logic        err;

  branch_condition_resolver #(
    .ADDR_W      (16),
    .PENDING_MAX (3)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flags        (flags),
    .flag_issue   (flag_issue),
    .flag_commit  (flag_commit),
    .br_valid     (br_valid),
    .br_ready     (br_ready),
    .br_cond      (br_cond),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .stall_cycles (stall_cycles),
    .err          (err)
  );

  typedef struct {
    logic        taken;
    logic [15:0] target;
    logic [7:0]  stall;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   seen_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference condition table, flags = {N, Z, C, V}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one branch for a single cycle (DUT must be idle); optionally queue its expectation.
  task automatic send_branch(input logic [3:0] cond, input logic [15:0] pc, input logic [15:0] off,
                             input logic taken, input logic [7:0] stall, input int lat,
                             input bit push);
    exp_t e;
    br_valid  = 1'b1;
    br_cond   = cond;
    br_pc     = pc;
    br_offset = off;
    if (push) begin
      e.taken  = taken;
      e.target = taken ? pc + off : pc + 16'd1;
      e.stall  = stall;
      e.lat    = lat;
      exp_q.push_back(e);
    end
    step();
    br_valid = 1'b0;
  endtask

  // Wait until every queued result has been handed over; DUT is back in idle on return.
  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Result monitor: latency at first res_valid, values at handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen_valid = 0;
    end else begin
      if (br_valid && br_ready) accept_cyc = cyc;
      if (res_valid && !seen_valid) begin
        seen_valid = 1;
        if (exp_q.size() == 0) check_eq("unexpected_result", res_valid, 1'b0);
        else check_eq("latency", cyc - accept_cyc, exp_q[0].lat);
      end
      if (res_valid && res_ready) begin
        seen_valid = 0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("res_taken", res_taken, e.taken);
          check_eq("res_target", res_target, e.target);
          check_eq("stall_cycles", stall_cycles, e.stall);
        end
      end
    end
  end

  logic [3:0] flag_pats [7];

  initial begin
    flag_pats[0] = 4'b0000; flag_pats[1] = 4'b0100; flag_pats[2] = 4'b0010;
    flag_pats[3] = 4'b1001; flag_pats[4] = 4'b1000; flag_pats[5] = 4'b0110;
    flag_pats[6] = 4'b0001;

    rst = 1'b1; flags = 4'b0000; flag_issue = 1'b0; flag_commit = 1'b0;
    br_valid = 1'b0; br_cond = 4'd0; br_pc = 16'd0; br_offset = 16'd0; res_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_br_ready", br_ready, 1'b1);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_res_taken", res_taken, 1'b0);
    check_eq("rst_res_target", res_target, 16'h0000);
    check_eq("rst_stall", stall_cycles, 8'd0);
    check_eq("rst_err", err, 1'b0);
    step();

    // EQ with Z set, nothing pending.
    flags = 4'b0100;
    send_branch(4'd0, 16'h0010, 16'h0008, 1'b1, 8'd0, 2, 1'b1);
    wait_done();

    // Two older flag writers; commits 3 and 6 cycles after accept; GE on final flags.
    flags = 4'b1000;
    flag_issue = 1'b1;
    repeat (2) step();
    flag_issue = 1'b0;
    send_branch(4'd10, 16'h0100, 16'hFFF0, 1'b1, 8'd6, 8, 1'b1);
    repeat (2) step();
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    repeat (2) step();
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    flags = 4'b1001;
    wait_done();

    // Issue in the same cycle as accept: branch must wait for that commit.
    flags = 4'b0000;
    flag_issue = 1'b1;
    send_branch(4'd1, 16'h1234, 16'h0040, 1'b0, 8'd1, 3, 1'b1);
    flag_issue = 1'b0;
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    flags = 4'b0100;
    wait_done();

    // NV and AL with address wrap.
    send_branch(4'd15, 16'hFFFF, 16'h0005, 1'b0, 8'd0, 1, 1'b1);
    wait_done();
    send_branch(4'd14, 16'hFFF0, 16'h0020, 1'b1, 8'd0, 1, 1'b1);
    wait_done();

    // Back-pressure: result must stay stable while flags toggle.
    res_ready = 1'b0;
    flags = 4'b0100;
    send_branch(4'd0, 16'h2000, 16'h0100, 1'b1, 8'd0, 2, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_res_valid", res_valid, 1'b1);
      check_eq("hold_res_taken", res_taken, 1'b1);
      check_eq("hold_res_target", res_target, 16'h2100);
      check_eq("hold_br_ready", br_ready, 1'b0);
      step();
      flags = ~flags;
    end
    res_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check_eq("post_hs_br_ready", br_ready, 1'b1);
    check_eq("post_hs_res_valid", res_valid, 1'b0);
    step();

    // Sweep every condition code over several flag patterns.
    for (int p = 0; p < 7; p++) begin
      flags = flag_pats[p];
      for (int c = 0; c < 16; c++) begin
        send_branch(4'(c), 16'(16'h0300 + 16 * c), 16'(16'h0A00 - p), ref_cond(4'(c), flag_pats[p]),
                    8'd0, (c >= 14) ? 1 : 2, 1'b1);
        wait_done();
      end
    end

    // Overflow: four issues with a limit of three.
    flag_issue = 1'b1;
    repeat (4) step();
    flag_issue = 1'b0;
    @(negedge clk);
    check_eq("ovf_err", err, 1'b1);
    step();
    send_branch(4'd0, 16'h0500, 16'h0010, 1'b0, 8'd0, 0, 1'b0);
    flag_commit = 1'b1;
    repeat (2) step();
    flag_commit = 1'b0;
    @(negedge clk);
    check_eq("ovf_still_wait_ready", br_ready, 1'b0);
    check_eq("ovf_still_wait_valid", res_valid, 1'b0);
    check_eq("ovf_err_sticky", err, 1'b1);
    step();

    // Reset while waiting.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("wrst_br_ready", br_ready, 1'b1);
    check_eq("wrst_res_valid", res_valid, 1'b0);
    check_eq("wrst_res_taken", res_taken, 1'b0);
    check_eq("wrst_res_target", res_target, 16'h0000);
    check_eq("wrst_stall", stall_cycles, 8'd0);
    check_eq("wrst_err", err, 1'b0);
    step();

    // Pending cleared by reset: branch resolves without waiting.
    flags = 4'b0100;
    send_branch(4'd0, 16'h0600, 16'h0002, 1'b1, 8'd0, 2, 1'b1);
    wait_done();

    // Underflow: commit with nothing pending.
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    @(negedge clk);
    check_eq("udf_err", err, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_condition_resolver.md
Name: branch_condition_resolver

Overview:
Consumer side of the 4-bit flags register. It accepts conditional-branch requests from decode and waits until every in-flight flag-setting instruction has committed. It then evaluates the condition code against the committed flags and returns taken/not-taken plus the next PC on a valid/ready result channel. It sits between decode and fetch-redirect.

Parameters:
ADDR_W, 16, width of PC, offset and target.
PENDING_MAX, 3, maximum flag-setting instructions in flight; pending counter width is clog2(PENDING_MAX+1).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flags  input  4  committed flags register output; [3]=N, [2]=Z, [1]=C, [0]=V.
flag_issue  input  1  pulse: a flag-setting instruction has issued.
flag_commit  input  1  pulse: flags register write enable (flags valid next cycle).
br_valid  input  1  branch request valid.
br_ready  output  1  resolver can accept a request.
br_cond  input  4  condition code.
br_pc  input  ADDR_W  PC of branch.
br_offset  input  ADDR_W  two's-complement branch offset.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts result.
res_taken  output  1  condition true.
res_target  output  ADDR_W  next PC.
stall_cycles  output  8  WAIT cycles spent by the most recent branch, saturating at 255.
err  output  1  sticky pending-counter overflow/underflow.

Behaviour:
- Reset (synchronous, active-high; applies in any state, including mid-operation):
  - FSM goes to IDLE; pending=0; captured request discarded.
  - br_ready=1 after reset deasserts; res_valid=0, res_taken=0, res_target=0, stall_cycles=0, err=0.
- Pending counter:
  - issue only: +1. commit only: -1. Both in the same cycle: unchanged.
  - issue when pending==PENDING_MAX: counter holds and err is set.
  - commit when pending==0: counter holds and err is set.
  - err clears only on reset.
- Ordering: a flag_issue in the same cycle a branch is accepted counts as older than the branch, so the branch waits for it. All wait decisions use the next-cycle pending value.
- FSM states:
  - IDLE: br_ready=1. On br_valid: capture cond, pc and offset; clear stall_cycles.
    - cond 14 (AL) or 15 (NV): go to DONE directly; flags are not needed; 1-cycle latency.
    - Other cond, next pending==0: go to EVAL.
    - Other cond, next pending>0: go to WAIT.
  - WAIT: br_ready=0. stall_cycles increments each cycle (saturating). Go to EVAL on the edge where next pending becomes 0.
  - EVAL: sample flags this cycle. Flags are guaranteed current because the last commit's register edge has already occurred. Register res_taken and res_target; go to DONE.
  - DONE: res_valid=1; outputs stable. On res_ready go to IDLE; no new request is accepted in that same cycle.
- Latency from accept to res_valid: 1 cycle for AL/NV; 2 cycles with no pending flag writes; 2+W cycles with W wait cycles.
- Condition codes (0..15): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
- Target arithmetic:
  - taken: pc+offset, modulo 2^ADDR_W (wraps, no carry out).
  - not taken: pc+1, modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
- Flags changing while in WAIT or DONE do not alter the registered result.

Test Plan:
- pending=0, flags=0100 (Z), br_cond=0 (EQ), pc=0x0010, offset=0x0008 -> res_valid 2 cycles after accept; taken=1; target=0x0018; stall_cycles=0.
- Issue 2 flag instructions, branch cond=10 (GE); commits 3 and 6 cycles later with final flags=1001 (N=V) -> branch held in WAIT; resolves on final flags; taken=1; stall_cycles equals wait count.
- Branch accepted in the same cycle as flag_issue, cond=1 (NE) -> waits for that commit; flags=0100 -> taken=0; target=pc+1.
- cond=15 (NV), pc=0xFFFF -> res_valid 1 cycle after accept; taken=0; target=0x0000. cond=14 (AL), pc=0xFFF0, offset=0x0020 -> target=0x0010.
- Hold res_ready=0 for 5 cycles while flags toggle -> res_valid, taken and target stable; br_ready=0 throughout; IDLE after handshake.
- 4 issues with PENDING_MAX=3 -> err=1, pending stays 3. Assert rst while in WAIT -> next cycle IDLE, res_valid=0, err=0, pending=0.
